// File: rtl/hub_dma_if.sv
// Hub bus slot of one cog-side DMA initiator.
// Outputs of every initiator are OR-combined onto the hub.
interface hub_dma_if;
  logic        ena_bus;
  logic        bus_sel;
  logic        bus_r;
  logic        bus_e;
  logic        bus_w;
  logic [1:0]  bus_s;
  logic [15:0] bus_a;
  logic [31:0] bus_d;
  logic [31:0] bus_q;
  logic        bus_ack;

  modport master (
    input  ena_bus, bus_sel, bus_q, bus_ack,
    output bus_r, bus_e, bus_w, bus_s, bus_a, bus_d
  );

  modport slave (
    output ena_bus, bus_sel, bus_q, bus_ack,
    input  bus_r, bus_e, bus_w, bus_s, bus_a, bus_d
  );
endinterface

// File: rtl/hub_dma.sv
// Long-word hub DMA with read-data FIFO, one request in flight.
// Write support is compiled in by defining HUB_DMA_WRITE_EN.
module hub_dma #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_cog,
  input  logic        nres,
  hub_dma_if.master   bus,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_count,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE, WAIT_SLOT, WAIT_ACK, DRAIN
  } state_t;

  state_t      state, state_nx;
  logic [15:0] addr;
  logic [8:0]  cnt;
  logic [31:0] mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr, occ;
  logic        empty, full;
  logic        accept, issue, ack;
  logic        push, pop, eligible;

`ifdef HUB_DMA_WRITE_EN
  logic        wflag;
  assign eligible = wflag ? wr_valid : !full;
  assign push     = ack && !wflag;
`else
  logic        unused_wr;
  assign unused_wr = ^{wr_valid, wr_data};
  assign eligible  = !full;
  assign push      = ack;
`endif

  assign occ      = wptr - rptr;
  assign empty    = (wptr == rptr);
  assign full     = occ[AW];
  assign rd_valid = nres && !empty;
  assign rd_data  = mem[rptr[AW-1:0]];
  assign pop      = rd_valid && rd_ready;

  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    issue     = 1'b0;
    ack       = 1'b0;
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    busy      = (state != IDLE);
    bus.bus_r = 1'b0;
    bus.bus_e = 1'b0;
    bus.bus_w = 1'b0;
    bus.bus_s = 2'b00;
    bus.bus_a = 16'h0000;
    bus.bus_d = 32'h0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
`ifdef HUB_DMA_WRITE_EN
          accept   = 1'b1;
          state_nx = WAIT_SLOT;
`else
          if (cmd_write) begin
            err = 1'b1;
          end else begin
            accept   = 1'b1;
            state_nx = WAIT_SLOT;
          end
`endif
        end
      end
      WAIT_SLOT: begin
        if (bus.bus_sel && bus.ena_bus && eligible) begin
          issue     = 1'b1;
          bus.bus_r = 1'b1;
          bus.bus_e = 1'b1;
          bus.bus_s = 2'b10;
          bus.bus_a = addr;
`ifdef HUB_DMA_WRITE_EN
          bus.bus_w = wflag;
          wr_ready  = wflag;
          bus.bus_d = wflag ? wr_data : 32'h0;
`endif
          state_nx  = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (bus.bus_ack) begin
          ack      = 1'b1;
          state_nx = (cnt == 9'd1) ? DRAIN : WAIT_SLOT;
        end
      end
      DRAIN: begin
        if (empty) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    // Reset dominates so the hub sees a silent initiator.
    if (!nres) begin
      state_nx  = IDLE;
      accept    = 1'b0;
      issue     = 1'b0;
      ack       = 1'b0;
      cmd_ready = 1'b1;
      wr_ready  = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      busy      = 1'b0;
      bus.bus_r = 1'b0;
      bus.bus_e = 1'b0;
      bus.bus_w = 1'b0;
      bus.bus_s = 2'b00;
      bus.bus_a = 16'h0000;
      bus.bus_d = 32'h0;
    end
  end

  always_ff @(posedge clk_cog) begin
    if (!nres) begin
      state <= IDLE;
      addr  <= 16'h0000;
      cnt   <= 9'd0;
      wptr  <= '0;
      rptr  <= '0;
`ifdef HUB_DMA_WRITE_EN
      wflag <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (accept) begin
        addr  <= {cmd_addr[15:2], 2'b00};
        cnt   <= {(cmd_count == 8'd0), cmd_count};
`ifdef HUB_DMA_WRITE_EN
        wflag <= cmd_write;
`endif
      end else if (ack) begin
        addr <= addr + 16'd4;
        cnt  <= cnt - 9'd1;
      end
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk_cog) begin
    if (push) mem[wptr[AW-1:0]] <= bus.bus_q;
  end

endmodule

// File: tb/tb_hub_dma.sv
// Scoreboard bench for hub_dma with a slot-rotating hub model.
// Write path is exercised when HUB_DMA_WRITE_EN is defined.
module tb_hub_dma;

  logic        clk = 1'b0;
  logic        nres;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_count;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid, rd_ready;
  logic [31:0] rd_data;
  logic        busy, done, err;

  hub_dma_if hb();

  hub_dma #(.FIFO_DEPTH(4)) dut (
    .clk_cog   (clk),
    .nres      (nres),
    .bus       (hb.master),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_count (cmd_count),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int req_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int wr_pulses = 0;
  int rd_mode = 1;
  int ack_lat = 1;
  bit sel_en = 1'b1;
  bit exp_w = 1'b0;
  logic [15:0] exp_addr [$];
  logic [31:0] exp_data [$];

  task automatic chk(string tag, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               tag, act, exp);
    end
  endtask

  function automatic logic [31:0] hub_q(logic [15:0] a);
    return {~a, a};
  endfunction

  // Hub: 8 cogs x 2 phases, this initiator owns cog 5.
  initial begin
    logic [3:0]  slot;
    logic [31:0] qv;
    bit          pend, wtaken;
    int          lat;
    slot = 4'd0; qv = 32'h0; pend = 0; lat = 0;
    hb.bus_ack = 1'b0; hb.bus_q = 32'h0;
    hb.ena_bus = 1'b0; hb.bus_sel = 1'b0;
    rd_ready = 1'b0; wr_valid = 1'b0; wr_data = 32'h0;
    forever begin
      @(negedge clk);
      wtaken = 0;
      if (hb.bus_r) begin
        req_cnt++;
        chk("req_sel", hb.bus_sel, 1);
        chk("req_e", hb.bus_e, 1);
        chk("req_s", hb.bus_s, 2'b10);
        chk("req_w", hb.bus_w, exp_w);
        chk("req_wr_ready", wr_ready, exp_w);
        if (exp_addr.size() == 0)
          chk("req_extra", 1, 0);
        else
          chk("bus_a", hb.bus_a, exp_addr.pop_front());
        if (exp_w) chk("bus_d", hb.bus_d, wr_data);
        pend = 1; lat = ack_lat; qv = hub_q(hb.bus_a);
      end else begin
        chk("bus_idle", |{hb.bus_e, hb.bus_w, hb.bus_s,
                          hb.bus_a, hb.bus_d, wr_ready}, 0);
      end
      if (wr_ready) begin wr_pulses++; wtaken = 1; end
      if (done) done_cnt++;
      if (err)  err_cnt++;
      if (rd_valid && rd_ready) begin
        if (exp_data.size() == 0)
          chk("rd_extra", 1, 0);
        else
          chk("rd_data", rd_data, exp_data.pop_front());
      end
      @(posedge clk); #1;
      slot++;
      hb.ena_bus = slot[0];
      hb.bus_sel = sel_en && (slot[3:1] == 3'd5);
      hb.bus_ack = 1'b0;
      if (pend) begin
        if (lat == 0) begin
          hb.bus_ack = 1'b1; hb.bus_q = qv; pend = 0;
        end else lat--;
      end
      case (rd_mode)
        0: rd_ready = 1'b0;
        1: rd_ready = 1'b1;
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      if (wtaken || !wr_valid) begin
        wr_valid = ($urandom_range(0, 2) != 0);
        wr_data  = $urandom;
      end
    end
  end

  task automatic send_cmd(bit w, logic [15:0] a,
                          logic [7:0] c);
    int n;
    logic [15:0] ea;
    n  = (c == 8'd0) ? 256 : int'(c);
    ea = {a[15:2], 2'b00};
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = w;
    cmd_addr = a; cmd_count = c;
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(ea);
      if (!w) exp_data.push_back(hub_q(ea));
      ea = ea + 16'd4;
    end
    @(negedge clk);
    chk("cmd_ready", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_write = 1'b0;
  endtask

  task automatic wait_done(int bound);
    int d0;
    bit hit;
    d0 = done_cnt; hit = 0;
    for (int i = 0; i < bound && !hit; i++) begin
      @(posedge clk);
      if (done_cnt != d0) hit = 1;
    end
    chk("done_seen", hit, 1);
  endtask

  task automatic xfer(bit w, logic [15:0] a,
                      logic [7:0] c, int bound);
    int r0, d0, n;
    r0 = req_cnt; d0 = done_cnt;
    n = (c == 8'd0) ? 256 : int'(c);
    send_cmd(w, a, c);
    wait_done(bound);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("xfer_reqs", req_cnt - r0, n);
    chk("done_once", done_cnt - d0, 1);
    chk("addr_q_empty", exp_addr.size(), 0);
    chk("data_q_empty", exp_data.size(), 0);
    chk("busy_end", busy, 0);
  endtask

  initial begin
    int r0, d0, e0, w0;
    bit hit;
    nres = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = 16'h0; cmd_count = 8'h0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_done_err", {done, err}, 0);
    chk("rst_bus_r", hb.bus_r, 0);
    @(posedge clk); #1;
    nres = 1'b1;

    // basic read, then unaligned start address
    xfer(0, 16'h0100, 8'd4, 600);
    xfer(0, 16'h0203, 8'd2, 400);

    // FIFO backpressure stalls issue after 4 longs
    rd_mode = 0;
    r0 = req_cnt; d0 = done_cnt;
    send_cmd(0, 16'h0800, 8'd8);
    repeat (300) @(posedge clk);
    @(negedge clk);
    chk("stall_reqs", req_cnt - r0, 4);
    chk("stall_busy", busy, 1);
    chk("stall_rd_valid", rd_valid, 1);
    rd_mode = 1;
    wait_done(600);
    repeat (3) @(posedge clk);
    chk("stall_total", req_cnt - r0, 8);
    chk("stall_done", done_cnt - d0, 1);
    chk("stall_q_empty", exp_data.size(), 0);

    // 256 longs, random rd_ready, address wraps
    rd_mode = 2;
    xfer(0, 16'hFFF0, 8'd0, 6000);
    rd_mode = 1;

`ifdef HUB_DMA_WRITE_EN
    exp_w = 1'b1;
    w0 = wr_pulses;
    xfer(1, 16'hFFF8, 8'd3, 600);
    chk("wr_pulses", wr_pulses - w0, 3);
    exp_w = 1'b0;
`else
    e0 = err_cnt; r0 = req_cnt; w0 = wr_pulses;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b1;
    cmd_addr = 16'h0500; cmd_count = 8'd2;
    @(negedge clk);
    chk("err_pulse", err, 1);
    chk("err_cmd_ready", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_write = 1'b0;
    @(negedge clk);
    chk("err_low", err, 0);
    chk("err_busy", busy, 0);
    chk("err_cmd_ready2", cmd_ready, 1);
    repeat (40) @(posedge clk);
    chk("err_once", err_cnt - e0, 1);
    chk("err_no_req", req_cnt - r0, 0);
    chk("err_no_wr", wr_pulses - w0, 0);
`endif

    // no slot grant means no progress
    sel_en = 1'b0;
    r0 = req_cnt;
    send_cmd(0, 16'h0300, 8'd2);
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("nosel_reqs", req_cnt - r0, 0);
    chk("nosel_busy", busy, 1);
    sel_en = 1'b1;
    wait_done(400);
    chk("nosel_resume", req_cnt - r0, 2);

    // reset while waiting for ack; late ack ignored
    ack_lat = 6;
    r0 = req_cnt; d0 = done_cnt; hit = 0;
    send_cmd(0, 16'h0400, 8'd4);
    for (int i = 0; i < 100 && !hit; i++) begin
      @(posedge clk);
      if (req_cnt != r0) hit = 1;
    end
    chk("rst_req_seen", hit, 1);
    #1 nres = 1'b0;
    @(posedge clk); #1;
    nres = 1'b1;
    exp_addr.delete();
    exp_data.delete();
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_rd_valid", rd_valid, 0);
    chk("abort_cmd_ready", cmd_ready, 1);
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_rd_late", rd_valid, 0);
    chk("abort_busy_late", busy, 0);
    chk("abort_reqs", req_cnt - r0, 1);
    ack_lat = 1;

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/hub_dma.md
HUB_DMA -- requirements
Module: hub_dma

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, read-data FIFO depth in longs (power of 2, 2..16).
REQ-002 SHALL have port clk_cog  in  1  cog clock, the only clock.
REQ-003 SHALL have port nres  in  1  reset, synchronous, active-low.
REQ-004 SHALL have ports ena_bus  in  1  hub phase, and bus_sel  in  1  this initiator's hub slot.
REQ-005 SHALL have ports bus_r, bus_e, bus_w  out  1 each: request, enable, write.
REQ-006 SHALL have ports bus_s  out  2  size (2'b10 = long), bus_a  out  16  byte address, and bus_d  out  32  write data.
REQ-007 SHALL have ports bus_q  in  32  read data, and bus_ack  in  1  hub acknowledge for this slot.
REQ-008 SHALL have command ports cmd_valid in 1, cmd_ready out 1, cmd_write in 1, cmd_addr in 16, cmd_count in 8 (longs; 0 means 256).
REQ-009 SHALL have write-stream ports wr_valid in 1, wr_ready out 1, wr_data in 32.
REQ-010 SHALL have read-stream ports rd_valid out 1, rd_ready in 1, rd_data out 32.
REQ-011 SHALL have status ports busy out 1, done out 1 (pulse), err out 1 (pulse).

Function
REQ-012 SHALL drive bus_r/e/w/s/a/d all-zero whenever bus_sel=0 or no request is issued (outputs are OR-combined with other initiators).
REQ-013 SHALL use FSM states IDLE, WAIT_SLOT, WAIT_ACK, DRAIN; cmd_ready=1 only in IDLE.
REQ-014 SHALL, in IDLE on cmd_valid, latch cmd_write, cmd_addr with [1:0] forced to 0, and cmd_count; assert busy; go to WAIT_SLOT.
REQ-015 SHALL issue a request in the cycle bus_sel=1 and ena_bus=1 in WAIT_SLOT, if eligible, driving bus_r=1, bus_e=1, bus_s=2'b10, bus_a=current address, bus_w=write flag; then go to WAIT_ACK.
REQ-016 SHALL treat a write as eligible only when wr_valid=1; wr_ready SHALL pulse 1 in the issue cycle only, and bus_d=wr_data in that cycle.
REQ-017 SHALL treat a read as eligible only when FIFO occupancy < FIFO_DEPTH; at most one request SHALL be outstanding.
REQ-018 SHALL hold in WAIT_ACK until bus_ack=1; on that edge a read SHALL push bus_q into the FIFO.
REQ-019 SHALL, on ack, add 4 to the address modulo 2^16 (0xFFFC -> 0x0000) and decrement the remaining count.
REQ-020 SHALL, on ack, return to WAIT_SLOT if count remains, else go to DRAIN; the next request SHALL not occur before the next qualifying slot cycle.
REQ-021 SHALL, in DRAIN, wait until the FIFO is empty, then pulse done for one cycle, deassert busy, and enter IDLE.
REQ-022 SHALL present rd_valid=1 when the FIFO is non-empty, with rd_data = oldest entry; pop on rd_valid & rd_ready; FIFO push and pop in the same cycle SHALL both take effect.
REQ-023 SHALL deliver FIFO data in address order with no loss or duplication under any rd_ready pattern.
REQ-024 SHALL ignore cmd_valid while not in IDLE (no queuing).

Reset
REQ-025 SHALL, on nres=0 at a clk_cog edge, go to IDLE, flush the FIFO, and clear the count and address.
REQ-026 SHALL hold these output values during reset: bus_* = 0, cmd_ready=1, wr_ready=0, rd_valid=0, busy=0, done=0, err=0.
REQ-027 SHALL, on reset mid-transfer, abort the transfer, discard any outstanding ack, and produce no done pulse.

Configuration
REQ-028 SHALL compile in write support when HUB_DMA_WRITE_EN is defined.
REQ-029 SHALL, when HUB_DMA_WRITE_EN is undefined, accept cmd_write=1 commands only to pulse err for 1 cycle and stay in IDLE; bus_w and wr_ready SHALL be tied to 0.

Verification
REQ-030 SHALL cover: read, addr 0x0100, count 4, 8 cogs' slot rotation, rd_ready=1 -> four bus_q values out in order; bus_a = 0x0100, 0x0104, 0x0108, 0x010C; one done pulse.
REQ-031 SHALL cover: read, count 8, FIFO_DEPTH 4, rd_ready=0 -> exactly 4 requests issued and then stall; releasing rd_ready -> remaining 4 complete.
REQ-032 SHALL cover: write, addr 0xFFF8, count 3, wr_valid gaps -> bus_a = 0xFFF8, 0xFFFC, 0x0000; bus_w=1; bus_d matches wr_data; wr_ready pulses 3 times.
REQ-033 SHALL cover: bus_sel=0 throughout -> all bus_* outputs 0 and no progress.
REQ-034 SHALL cover: nres=0 while in WAIT_ACK -> the next cycle shows IDLE, rd_valid=0, busy=0, no done; a late bus_ack is ignored.
REQ-035 SHALL cover: without HUB_DMA_WRITE_EN, a write command -> err pulses once, no bus activity, cmd_ready stays 1.
